// File: rtl/sram_like_arb_bridge.sv
// sram_like_arb_bridge: shares one SRAM-like master port between NCH core-side
// SRAM channels. Only one transaction is outstanding at a time. Each result is
// held in a per-channel register until the global pipeline stall releases it.
// Optional feature: define BRIDGE_RR_ARB_EN to use round-robin arbitration.
// Without it, arbitration is fixed priority and the lowest index wins.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no transaction in flight; arbitrate among pending channels
// ADDR   | request presented (req=1) until addr_ok
// DATA   | waiting for data_ok; capture read data into cur's holding reg
module sram_like_arb_bridge #(
    parameter int NCH = 2,
    parameter int AW  = 32,
    parameter int DW  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NCH-1:0]          ch_en_i,
    input  logic [NCH*(DW/8)-1:0]   ch_wen_i,
    input  logic [NCH*AW-1:0]       ch_addr_i,
    input  logic [NCH*DW-1:0]       ch_wdata_i,
    output logic [NCH*DW-1:0]       ch_rdata_o,
    output logic [NCH-1:0]          ch_stall_o,
    input  logic                    longest_stall_i,
    output logic                    req_o,
    output logic                    wr_o,
    output logic [1:0]              size_o,
    output logic [AW-1:0]           addr_o,
    output logic [DW-1:0]           wdata_o,
    input  logic                    addr_ok_i,
    input  logic                    data_ok_i,
    input  logic [DW-1:0]           rdata_i
);

    localparam int WB = DW / 8;
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cur_q, cur_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            wr_q, wr_d;
    logic [1:0]      size_q, size_d;
    logic [NCH-1:0]  done_q, done_d;
    logic [DW-1:0]   rdata_q [NCH];
    logic [DW-1:0]   rdata_d [NCH];

    logic [NCH-1:0]  pending;
    logic            busy;
    logic            gnt_vld;
    logic [CW-1:0]   gnt_idx;
    logic [WB-1:0]   sel_wen;

`ifdef BRIDGE_RR_ARB_EN
    logic [CW-1:0]   rr_ptr_q, rr_ptr_d;
`endif

    // Byte-lane pattern to transfer size; anything irregular goes out as a word.
    function automatic logic [1:0] size_of(input logic [3:0] wen);
        case (wen)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: size_of = 2'd0;
            4'b0011, 4'b1100:                   size_of = 2'd1;
            default:                            size_of = 2'd2;
        endcase
    endfunction

    assign busy       = (state_q != S_IDLE);
    assign ch_stall_o = ch_en_i & ~done_q;

    // A channel is pending if it requests, has no held result and is not already in flight.
    always_comb begin
        pending = '0;
        for (int i = 0; i < NCH; i++) begin
            pending[i] = ch_en_i[i] & ~done_q[i] & ~(busy & (cur_q == CW'(i)));
        end
    end

`ifdef BRIDGE_RR_ARB_EN
    // Round-robin grant: first pending channel at or after the priority pointer.
    always_comb begin
        int idx;
        idx     = 0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr_q) + k) % NCH;
            if (pending[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = CW'(idx);
            end
        end
    end
`else
    // Fixed-priority grant: lowest pending index wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (pending[i]) begin
                gnt_vld = 1'b1;
                gnt_idx = CW'(i);
            end
        end
    end
`endif

    assign sel_wen = ch_wen_i[int'(gnt_idx)*WB +: WB];

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (gnt_vld)   state_d = S_ADDR;
            S_ADDR:  if (addr_ok_i) state_d = S_DATA;
            S_DATA:  if (data_ok_i) state_d = S_IDLE;
            default:                state_d = S_IDLE;
        endcase
    end

    // FSM outputs: request only in ADDR; everything else comes from latched values.
    always_comb begin
        req_o   = (state_q == S_ADDR);
        wr_o    = wr_q;
        size_o  = size_q;
        addr_o  = addr_q;
        wdata_o = wdata_q;
    end

    // Latch the granted channel's request and update done flags / held read data.
    always_comb begin
        cur_d   = cur_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        size_d  = size_q;
        if (state_q == S_IDLE && gnt_vld) begin
            cur_d   = gnt_idx;
            addr_d  = ch_addr_i[int'(gnt_idx)*AW +: AW];
            wdata_d = ch_wdata_i[int'(gnt_idx)*DW +: DW];
            wr_d    = |sel_wen;
            size_d  = size_of(sel_wen);
        end
        for (int i = 0; i < NCH; i++) begin
            rdata_d[i] = rdata_q[i];
            // A held result is released once the pipeline is no longer stalled.
            done_d[i]  = done_q[i] & longest_stall_i;
            if (state_q == S_DATA && data_ok_i && cur_q == CW'(i)) begin
                done_d[i] = 1'b1;
                if (!wr_q) rdata_d[i] = rdata_i;
            end
        end
    end

`ifdef BRIDGE_RR_ARB_EN
    // Priority pointer moves past the channel just granted.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (state_q == S_IDLE && gnt_vld) begin
            rr_ptr_d = (gnt_idx == CW'(NCH - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Priority pointer register.
    always_ff @(posedge clk) begin
        if (rst) rr_ptr_q <= '0;
        else     rr_ptr_q <= rr_ptr_d;
    end
`endif

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            size_q  <= 2'd0;
            done_q  <= '0;
            for (int i = 0; i < NCH; i++) rdata_q[i] <= '0;
        end else begin
            cur_q   <= cur_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            done_q  <= done_d;
            for (int i = 0; i < NCH; i++) rdata_q[i] <= rdata_d[i];
        end
    end

    // Flatten the held read data onto the channel bus.
    always_comb begin
        ch_rdata_o = '0;
        for (int i = 0; i < NCH; i++) ch_rdata_o[i*DW +: DW] = rdata_q[i];
    end

endmodule

// File: tb/tb_sram_like_arb_bridge.sv
// Directed bench for sram_like_arb_bridge (NCH=2, AW=DW=32).
// Each cycle: inputs are driven 1 ns after posedge, and outputs are checked 2 ns after posedge.
module tb_sram_like_arb_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  ch_en;
    logic [7:0]  ch_wen;
    logic [63:0] ch_addr;
    logic [63:0] ch_wdata;
    logic [63:0] ch_rdata;
    logic [1:0]  ch_stall;
    logic        longest_stall;
    logic        req, wr;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic        addr_ok, data_ok;
    logic [31:0] rdata;

    int nvec = 0;
    int nerr = 0;

`ifdef BRIDGE_RR_ARB_EN
    localparam int FIRST = 1;
`else
    localparam int FIRST = 0;
`endif
    localparam int SECOND = 1 - FIRST;

    logic [31:0] a_exp [2];
    logic [31:0] exp_rd0, exp_rd1;

    sram_like_arb_bridge #(.NCH(2), .AW(32), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .ch_en_i(ch_en), .ch_wen_i(ch_wen), .ch_addr_i(ch_addr), .ch_wdata_i(ch_wdata),
        .ch_rdata_o(ch_rdata), .ch_stall_o(ch_stall), .longest_stall_i(longest_stall),
        .req_o(req), .wr_o(wr), .size_o(size), .addr_o(addr), .wdata_o(wdata),
        .addr_ok_i(addr_ok), .data_ok_i(data_ok), .rdata_i(rdata)
    );

    always #5 clk = ~clk;

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One complete ch0 write with zero-wait handshakes, checking size/wr while req is high.
    task automatic size_case(input logic [3:0] wen, input logic [1:0] exp_sz, input string tag);
        nxt(); ch_en = 2'b01; ch_wen = {4'b0000, wen}; ch_addr[31:0] = 32'h0000_0100;
        addr_ok = 1'b1; data_ok = 1'b0; #1;
        nxt(); #1;
        check({tag, "_req"}, 64'(req), 64'd1);
        check({tag, "_size"}, 64'(size), 64'(exp_sz));
        check({tag, "_wr"}, 64'(wr), 64'd1);
        nxt(); addr_ok = 1'b0; data_ok = 1'b1; #1;
        nxt(); data_ok = 1'b0; ch_en = 2'b00; ch_wen = 8'h00; #1;
    endtask

    initial begin
        rst = 1'b1; ch_en = 2'b11; ch_wen = '0; ch_addr = '0; ch_wdata = '0;
        longest_stall = 1'b0; addr_ok = 1'b0; data_ok = 1'b0; rdata = '0;

        // Reset state
        nxt(); nxt(); #1;
        check("rst_req", 64'(req), 64'd0);
        check("rst_wr", 64'(wr), 64'd0);
        check("rst_size", 64'(size), 64'd0);
        check("rst_addr", 64'(addr), 64'd0);
        check("rst_wdata", 64'(wdata), 64'd0);
        check("rst_rdata", ch_rdata, 64'd0);
        check("rst_stall", 64'(ch_stall), 64'h3);
        ch_en = 2'b00;
        nxt(); rst = 1'b0; #1;

        // Single read on ch0, zero-wait handshakes
        nxt(); ch_en = 2'b01; ch_addr[31:0] = 32'hBFC0_0000; addr_ok = 1'b1; #1;
        check("t1_c0_req", 64'(req), 64'd0);
        check("t1_c0_stall", 64'(ch_stall), 64'h1);
        nxt(); #1;
        check("t1_c1_req", 64'(req), 64'd1);
        check("t1_c1_addr", 64'(addr), 64'hBFC0_0000);
        check("t1_c1_wr", 64'(wr), 64'd0);
        check("t1_c1_size", 64'(size), 64'd2);
        nxt(); addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h2408_0001; #1;
        check("t1_c2_req", 64'(req), 64'd0);
        check("t1_c2_stall", 64'(ch_stall), 64'h1);
        nxt(); data_ok = 1'b0; #1;
        check("t1_c3_stall", 64'(ch_stall), 64'h0);
        check("t1_c3_rdata0", 64'(ch_rdata[31:0]), 64'h2408_0001);
        ch_en = 2'b00;
        nxt(); #1;
        check("t1_c4_req", 64'(req), 64'd0);

        // Simultaneous requests from both channels
        a_exp[0] = 32'h1000_0000; a_exp[1] = 32'h2000_0004;
        nxt(); ch_en = 2'b11; ch_addr = {a_exp[1], a_exp[0]}; addr_ok = 1'b1; #1;
        check("t3_c0_stall", 64'(ch_stall), 64'h3);
        nxt(); #1;
        check("t3_c1_req", 64'(req), 64'd1);
        check("t3_c1_addr", 64'(addr), 64'(a_exp[FIRST]));
        check("t3_c1_stall", 64'(ch_stall), 64'h3);
        nxt(); addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'hAAAA_0001; #1;
        check("t3_c2_req", 64'(req), 64'd0);
        nxt(); data_ok = 1'b0; #1;
        check("t3_c3_stall", 64'(ch_stall), 64'(2'b01 << SECOND));
        check("t3_c3_req", 64'(req), 64'd0);
        check("t3_c3_rdfirst", 64'(ch_rdata[FIRST*32 +: 32]), 64'hAAAA_0001);
        ch_en = 2'(2'b01 << SECOND);
        nxt(); addr_ok = 1'b1; #1;
        check("t3_c4_req", 64'(req), 64'd1);
        check("t3_c4_addr", 64'(addr), 64'(a_exp[SECOND]));
        nxt(); addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'hBBBB_0002; #1;
        check("t3_c5_req", 64'(req), 64'd0);
        nxt(); data_ok = 1'b0; #1;
        check("t3_c6_stall", 64'(ch_stall), 64'h0);
        check("t3_c6_rdsecond", 64'(ch_rdata[SECOND*32 +: 32]), 64'hBBBB_0002);
        ch_en = 2'b00;
        exp_rd0 = (FIRST == 0) ? 32'hAAAA_0001 : 32'hBBBB_0002;
        exp_rd1 = (FIRST == 1) ? 32'hAAAA_0001 : 32'hBBBB_0002;

        // ch1 half-word store with addr_ok delayed three cycles
        nxt(); ch_en = 2'b10; ch_wen = 8'b0011_0000;
        ch_addr[63:32] = 32'h8000_0010; ch_wdata[63:32] = 32'h1234_5678; #1;
        check("t2_c0_stall", 64'(ch_stall), 64'h2);
        for (int c = 1; c <= 3; c++) begin
            nxt(); #1;
            check("t2_wait_req", 64'(req), 64'd1);
            check("t2_wait_wr", 64'(wr), 64'd1);
            check("t2_wait_size", 64'(size), 64'd1);
            check("t2_wait_addr", 64'(addr), 64'h8000_0010);
            check("t2_wait_wdata", 64'(wdata), 64'h1234_5678);
            ch_wdata[63:32] = 32'hDEAD_BEEF;
        end
        nxt(); addr_ok = 1'b1; #1;
        check("t2_c4_req", 64'(req), 64'd1);
        check("t2_c4_wdata", 64'(wdata), 64'h1234_5678);
        nxt(); addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h7777_7777; #1;
        check("t2_c5_req", 64'(req), 64'd0);
        nxt(); data_ok = 1'b0; #1;
        check("t2_c6_stall", 64'(ch_stall), 64'h0);
        check("t2_c6_rdata1", 64'(ch_rdata[63:32]), 64'(exp_rd1));
        ch_en = 2'b00; ch_wen = 8'h00;

        // Size decode for several byte-lane patterns
        size_case(4'b0100, 2'd0, "sz_b2");
        size_case(4'b1000, 2'd0, "sz_b3");
        size_case(4'b1100, 2'd1, "sz_hhi");
        size_case(4'b0111, 2'd2, "sz_odd");
        size_case(4'b1111, 2'd2, "sz_word");

        // ch0 completes while the global stall is held for four cycles
        nxt(); ch_en = 2'b01; ch_addr[31:0] = 32'h1000_0040; longest_stall = 1'b1; addr_ok = 1'b1; #1;
        check("t4_c0_stall", 64'(ch_stall), 64'h1);
        nxt(); #1;
        check("t4_c1_req", 64'(req), 64'd1);
        nxt(); addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'hCAFE_F00D; #1;
        nxt(); data_ok = 1'b0; rdata = 32'h1111_1111; #1;
        for (int c = 3; c <= 6; c++) begin
            check("t4_hold_stall", 64'(ch_stall), 64'h0);
            check("t4_hold_req", 64'(req), 64'd0);
            check("t4_hold_rdata0", 64'(ch_rdata[31:0]), 64'hCAFE_F00D);
            nxt(); #1;
        end
        longest_stall = 1'b0; #1;
        check("t4_c7_stall", 64'(ch_stall), 64'h0);
        check("t4_c7_req", 64'(req), 64'd0);
        nxt(); #1;
        check("t4_c8_stall", 64'(ch_stall), 64'h1);
        check("t4_c8_rdata0", 64'(ch_rdata[31:0]), 64'hCAFE_F00D);
        ch_en = 2'b00;
        nxt(); #1;
        check("t4_c9_req", 64'(req), 64'd0);

        // Reset in DATA, then a stale data_ok
        nxt(); ch_en = 2'b10; ch_addr[63:32] = 32'h9000_0000; addr_ok = 1'b1; #1;
        nxt(); #1;
        check("t5_c1_req", 64'(req), 64'd1);
        nxt(); addr_ok = 1'b0; #1;
        check("t5_c2_req", 64'(req), 64'd0);
        rst = 1'b1; ch_en = 2'b00;
        nxt(); rst = 1'b0; #1;
        check("t5_c3_req", 64'(req), 64'd0);
        check("t5_c3_rdata", ch_rdata, 64'd0);
        nxt(); data_ok = 1'b1; rdata = 32'hBAD0_BAD0; #1;
        check("t5_c4_req", 64'(req), 64'd0);
        nxt(); data_ok = 1'b0; ch_en = 2'b10; #1;
        check("t5_c5_stall", 64'(ch_stall), 64'h2);
        check("t5_c5_rdata", ch_rdata, 64'd0);
        ch_en = 2'b00;
        nxt(); #1;
        check("t5_c6_req", 64'(req), 64'd0);

        // ch1 drops ch_en while in ADDR
        nxt(); ch_en = 2'b10; ch_addr[63:32] = 32'h8000_0020; addr_ok = 1'b0; #1;
        nxt(); #1;
        check("t6_c1_req", 64'(req), 64'd1);
        ch_en = 2'b00;
        nxt(); addr_ok = 1'b1; #1;
        check("t6_c2_req", 64'(req), 64'd1);
        check("t6_c2_addr", 64'(addr), 64'h8000_0020);
        nxt(); addr_ok = 1'b0; #1;
        check("t6_c3_req", 64'(req), 64'd0);
        data_ok = 1'b1; rdata = 32'h5A5A_5A5A;
        nxt(); data_ok = 1'b0; #1;
        check("t6_c4_stall", 64'(ch_stall), 64'h0);
        check("t6_c4_rdata1", 64'(ch_rdata[63:32]), 64'h5A5A_5A5A);
        for (int c = 4; c <= 6; c++) begin
            check("t6_noreissue", 64'(req), 64'd0);
            nxt(); #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
